// File: rtl/ram_2r1w_wr_arbiter.sv
// Round-robin owner of the 2R1W RAM write port.
// Sweeps INIT_VAL over the whole array after reset/clear, then arbitrates.
module ram_2r1w_wr_arbiter #(
  parameter int          BLOCLSIZE = 10,
  parameter int          NREQ      = 4,
  parameter logic [31:0] INIT_VAL  = 32'h0000_0000,
  localparam int         AW        = BLOCLSIZE + 1,
  localparam int         PW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*32-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               w_enb,
  output logic [AW-1:0]      w_addr_1,
  output logic [31:0]        w_din_1,
  output logic               init_done,
  output logic [15:0]        wr_count
);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          w_enb_q, w_enb_d;
  logic [AW-1:0] w_addr_q, w_addr_d;
  logic [31:0]   w_din_q, w_din_d;
  logic          init_done_q, init_done_d;
  logic [15:0]   wr_count_q, wr_count_d;

  logic          gnt_vld;
  logic [PW-1:0] gnt_idx;
  logic          arb_en;
  logic          xfer;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_data;

  function automatic logic [PW-1:0] rr_idx(
    input logic [PW-1:0] base,
    input int            off
  );
    logic [PW:0] s;
    s = {1'b0, base} + (PW+1)'(off);
    if (s >= (PW+1)'(NREQ)) s = s - (PW+1)'(NREQ);
    return s[PW-1:0];
  endfunction

  // First RUN cycle has init_done_q low, so nobody is granted there.
  assign arb_en = (state_q == ST_RUN) & init_done_q & ~clear;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_vld && req_valid[rr_idx(ptr_q, k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = rr_idx(ptr_q, k);
      end
    end
  end

  assign xfer     = arb_en & gnt_vld;
  assign sel_addr = req_addr[int'(gnt_idx)*AW +: AW];
  assign sel_data = req_data[int'(gnt_idx)*32 +: 32];

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    w_enb_d     = 1'b0;
    w_addr_d    = w_addr_q;
    w_din_d     = w_din_q;
    init_done_d = init_done_q;
    wr_count_d  = wr_count_q;
    unique case (state_q)
      ST_INIT: begin
        init_done_d = 1'b0;
        if (clear) begin
          cnt_d = '0;
        end else begin
          w_enb_d  = 1'b1;
          w_addr_d = cnt_q;
          w_din_d  = INIT_VAL;
          cnt_d    = cnt_q + AW'(1);
          if (&cnt_q) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clear) begin
          state_d     = ST_INIT;
          cnt_d       = '0;
          init_done_d = 1'b0;
          wr_count_d  = '0;
        end else begin
          init_done_d = 1'b1;
          if (xfer) begin
            w_enb_d    = 1'b1;
            w_addr_d   = sel_addr;
            w_din_d    = sel_data;
            ptr_d      = rr_idx(gnt_idx, 1);
            wr_count_d = wr_count_q + 16'd1;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      ptr_q       <= '0;
      w_enb_q     <= 1'b0;
      w_addr_q    <= '0;
      w_din_q     <= '0;
      init_done_q <= 1'b0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      w_enb_q     <= w_enb_d;
      w_addr_q    <= w_addr_d;
      w_din_q     <= w_din_d;
      init_done_q <= init_done_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign w_enb     = w_enb_q;
  assign w_addr_1  = w_addr_q;
  assign w_din_1   = w_din_q;
  assign init_done = init_done_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_ram_2r1w_wr_arbiter.sv
// Bench for ram_2r1w_wr_arbiter: vector table, corner sequences,
// randomized traffic against a behavioural model.
module tb_ram_2r1w_wr_arbiter;

  localparam int          BLS   = 2;
  localparam int          NREQ  = 4;
  localparam int          AW    = BLS + 1;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] IV    = 32'hC0DE_0000;

  logic               clk = 1'b0;
  logic               rst;
  logic               clear;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               w_enb;
  logic [AW-1:0]      w_addr_1;
  logic [31:0]        w_din_1;
  logic               init_done;
  logic [15:0]        wr_count;

  logic [AW-1:0] ra [NREQ];
  logic [31:0]   rd [NREQ];

  ram_2r1w_wr_arbiter #(
    .BLOCLSIZE(BLS),
    .NREQ     (NREQ),
    .INIT_VAL (IV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_ready(req_ready),
    .w_enb    (w_enb),
    .w_addr_1 (w_addr_1),
    .w_din_1  (w_din_1),
    .init_done(init_done),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = ra[i];
      req_data[i*32 +: 32] = rd[i];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    clear     = 1'b0;
    req_valid = '0;
    #3;
    chk("rst w_enb", w_enb, 0);
    chk("rst w_addr", w_addr_1, 0);
    chk("rst w_din", w_din_1, 0);
    chk("rst init_done", init_done, 0);
    chk("rst wr_count", wr_count, 0);
    chk("rst ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_sweep(input logic [NREQ-1:0] vmask);
    for (int k = 0; k < DEPTH; k++) begin
      req_valid = vmask;
      #1;
      chk("sweep ready", req_ready, 0);
      step();
      chk("sweep w_enb", w_enb, 1);
      chk("sweep w_addr", w_addr_1, k);
      chk("sweep w_din", w_din_1, IV);
      chk("sweep init_done", init_done, 0);
    end
    #1;
    chk("first run ready", req_ready, 0);
    step();
    chk("first run w_enb", w_enb, 0);
    chk("first run init_done", init_done, 1);
    req_valid = '0;
  endtask

  typedef struct {
    logic [NREQ-1:0] v;
    logic [NREQ-1:0] exp_rdy;
    int              win;
    logic [15:0]     exp_cnt;
  } vec_t;

  vec_t tbl [12];

  // behavioural reference state
  bit              m_init, m_done;
  int              m_cnt, m_ptr, m_count;
  logic            e_enb;
  logic [AW-1:0]   e_addr;
  logic [31:0]     e_din;
  bit              pend [NREQ];

  initial begin
    logic [AW-1:0]   last_a;
    logic [31:0]     last_d;
    logic [NREQ-1:0] got_rdy;
    logic [NREQ-1:0] exp_rdy;
    int              win;

    tbl[0]  = '{4'b0100, 4'b0100,  2, 16'd1};
    tbl[1]  = '{4'b0000, 4'b0000, -1, 16'd1};
    tbl[2]  = '{4'b1000, 4'b1000,  3, 16'd2};
    tbl[3]  = '{4'b1111, 4'b0001,  0, 16'd3};
    tbl[4]  = '{4'b1111, 4'b0010,  1, 16'd4};
    tbl[5]  = '{4'b1111, 4'b0100,  2, 16'd5};
    tbl[6]  = '{4'b1111, 4'b1000,  3, 16'd6};
    tbl[7]  = '{4'b1111, 4'b0001,  0, 16'd7};
    tbl[8]  = '{4'b0010, 4'b0010,  1, 16'd8};
    tbl[9]  = '{4'b1010, 4'b1000,  3, 16'd9};
    tbl[10] = '{4'b1010, 4'b0010,  1, 16'd10};
    tbl[11] = '{4'b0000, 4'b0000, -1, 16'd10};

    ra[0] = 3'd1; rd[0] = 32'h1111_0000;
    ra[1] = 3'd6; rd[1] = 32'h2222_0000;
    ra[2] = 3'd5; rd[2] = 32'hA5A5_0001;
    ra[3] = 3'd2; rd[3] = 32'h4444_0000;

    // init sweep with everyone requesting
    do_reset();
    run_sweep(4'b1111);

    // arbitration vectors
    last_a = 3'd7;
    last_d = IV;
    for (int r = 0; r < 12; r++) begin
      req_valid = tbl[r].v;
      #1;
      chk("tbl ready", req_ready, tbl[r].exp_rdy);
      step();
      if (tbl[r].win >= 0) begin
        last_a = ra[tbl[r].win];
        last_d = rd[tbl[r].win];
      end
      chk("tbl w_enb", w_enb, (tbl[r].win >= 0) ? 1 : 0);
      chk("tbl w_addr", w_addr_1, last_a);
      chk("tbl w_din", w_din_1, last_d);
      chk("tbl wr_count", wr_count, tbl[r].exp_cnt);
    end

    // clear in RUN beats a pending request and reruns the sweep
    req_valid = 4'b0001;
    clear     = 1'b1;
    #1;
    chk("clear ready", req_ready, 0);
    step();
    clear = 1'b0;
    chk("clear w_enb", w_enb, 0);
    chk("clear init_done", init_done, 0);
    chk("clear wr_count", wr_count, 0);
    run_sweep(4'b0001);

    // async reset mid-sweep
    do_reset();
    for (int k = 0; k < 4; k++) step();
    chk("pre-rst w_addr", w_addr_1, 3);
    #2;
    rst = 1'b0;
    #1;
    chk("async rst w_enb", w_enb, 0);
    chk("async rst w_addr", w_addr_1, 0);
    @(negedge clk);
    rst = 1'b1;
    run_sweep(4'b0000);

    // randomized traffic vs model
    do_reset();
    m_init  = 1'b1;
    m_done  = 1'b0;
    m_cnt   = 0;
    m_ptr   = 0;
    m_count = 0;
    e_enb   = 1'b0;
    e_addr  = '0;
    e_din   = '0;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          ra[i]   = 3'($urandom);
          rd[i]   = $urandom;
        end
        req_valid[i] = pend[i];
      end
      clear = ($urandom_range(0, 149) == 0);
      #1;
      win = -1;
      if (!m_init && m_done && !clear)
        for (int k = 0; k < NREQ; k++)
          if (win < 0 && pend[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
      exp_rdy = '0;
      if (win >= 0) exp_rdy[win] = 1'b1;
      chk("rand ready", req_ready, exp_rdy);
      got_rdy = req_ready;
      step();
      if (m_init) begin
        m_done = 1'b0;
        if (clear) begin
          m_cnt = 0;
          e_enb = 1'b0;
        end else begin
          e_enb  = 1'b1;
          e_addr = 3'(m_cnt);
          e_din  = IV;
          m_cnt++;
          if (m_cnt == DEPTH) begin
            m_init = 1'b0;
            m_cnt  = 0;
          end
        end
      end else if (clear) begin
        m_init  = 1'b1;
        m_cnt   = 0;
        m_done  = 1'b0;
        e_enb   = 1'b0;
        m_count = 0;
      end else begin
        e_enb = 1'b0;
        if (win >= 0) begin
          e_enb   = 1'b1;
          e_addr  = ra[win];
          e_din   = rd[win];
          m_ptr   = (win + 1) % NREQ;
          m_count = (m_count + 1) % 65536;
        end
        m_done = 1'b1;
      end
      for (int i = 0; i < NREQ; i++)
        if (pend[i] && got_rdy[i]) pend[i] = 1'b0;
      chk("rand outputs",
          {w_enb, w_addr_1, w_din_1, init_done, wr_count},
          {e_enb, e_addr, e_din, m_done, 16'(m_count)});
    end
    clear     = 1'b0;
    req_valid = '0;

    // wr_count wraps at 16 bits
    do_reset();
    run_sweep(4'b0000);
    req_valid = 4'b0001;
    for (int k = 0; k < 65535; k++) step();
    chk("count at max", wr_count, 16'hFFFF);
    step();
    chk("count wrap", wr_count, 0);
    chk("wrap w_enb", w_enb, 1);
    req_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_2r1w_wr_arbiter.md
Name: ram_2r1w_wr_arbiter

Overview:
- Round-robin write-port controller for the replicated 2R1W RAM.
- Shares the single write port (w_addr_1 / w_din_1 / w_enb) among NREQ requesters using a valid/ready handshake, with one registered output stage.
- After reset, and on clear, sweeps every RAM address with INIT_VAL before accepting requests.
- Sits between requester logic and the RAM write port; RAM read ports are not touched.

Parameters:
- BLOCLSIZE, 10: address MSB index; address width AW = BLOCLSIZE+1, depth 2^AW.
- NREQ, 4: number of write requesters (2..8).
- INIT_VAL, 32'h0000_0000: data written during the init sweep.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous request to restart the init sweep.
- req_valid  in  NREQ  per-requester write request.
- req_addr  in  NREQ*AW  packed addresses; requester i at bits [i*AW +: AW].
- req_data  in  NREQ*32  packed data; requester i at bits [i*32 +: 32].
- req_ready  out  NREQ  one-hot or zero grant, combinational.
- w_enb  out  1  RAM write enable, registered.
- w_addr_1  out  AW  RAM write address, registered.
- w_din_1  out  32  RAM write data, registered.
- init_done  out  1  high in RUN state, registered.
- wr_count  out  16  count of accepted requester writes, registered.

Behaviour:
- Reset (rst=0, asynchronous, effective immediately, also mid-operation):
  - State INIT; sweep counter = 0; round-robin pointer ptr = 0.
  - w_enb=0, w_addr_1=0, w_din_1=0, init_done=0, wr_count=0.
  - Any in-progress sweep restarts from address 0.
- FSM states: INIT, RUN.
- INIT:
  - req_ready is all 0.
  - Each edge registers w_enb=1, w_addr_1=cnt, w_din_1=INIT_VAL, then cnt+1.
  - First edge after reset release writes address 0.
  - The edge writing address 2^AW-1 also moves the FSM to RUN.
  - On the following edge, init_done=1 and w_enb=0 (no requester accepted on that edge).
  - Total: 2^AW writes, then init_done rises on edge 2^AW+1.
- RUN arbitration:
  - Winner = first i with req_valid[i]=1, scanning ptr, ptr+1, ..., wrapping mod NREQ.
  - req_ready[winner]=1; all other bits 0; all 0 if no valid or clear=1.
- Transfer = req_valid[i] & req_ready[i] at a rising edge. On that edge:
  - w_enb<=1, w_addr_1<=req_addr[i], w_din_1<=req_data[i].
  - ptr <= (i+1) mod NREQ.
  - wr_count <= wr_count+1, wrapping 16'hFFFF -> 0.
- No transfer: w_enb<=0; w_addr_1, w_din_1 and ptr hold.
- Latency: request accepted in cycle N appears on the RAM port in cycle N+1. Sustained throughput is 1 write/cycle.
- Requester rules (not checked by the block):
  - Hold valid, addr and data stable until accepted.
  - valid must not depend on ready.
- clear:
  - In RUN: suppresses req_ready that cycle. Next edge: state INIT, cnt=0, init_done=0, w_enb=0, wr_count=0; ptr holds.
  - In INIT: restarts the sweep at address 0 on the next edge, with w_enb=0 on that edge.
  - Takes priority over any simultaneous request.
- Duplicate addresses from different requesters are written in grant order; no merging.

Test Plan:
- BLOCLSIZE=2, release reset -> w_enb=1 for 8 edges with addresses 0..7 and data INIT_VAL; req_ready=0 throughout; init_done=1 on edge 9.
- RUN, ptr=0, only req_valid[2]=1, addr 5, data 32'hA5A5_0001 -> req_ready=4'b0100 same cycle; next edge w_enb=1, w_addr_1=5, w_din_1=32'hA5A5_0001; ptr=3; wr_count=1.
- All four valid continuously, ptr=0 -> grants in order 0,1,2,3,0 on consecutive cycles; w_enb high each following cycle; wr_count +5.
- ptr=2, req_valid=4'b1010 -> requester 3 granted first, then requester 1; ptr ends at 2.
- RUN with clear=1 and req_valid[0]=1 -> req_ready=0, requester data never written; 8-address sweep repeats; wr_count=0; init_done low until the sweep ends.
- rst low during INIT at address 3 -> w_enb=0 immediately (asynchronous); after release, sweep restarts at address 0. Separately, wr_count at 16'hFFFF plus one accept -> 0.
